// File: rtl/bist_march_engine.sv
// bist_march_engine: March C- RAM test sequencer. RAM port outputs are
// registered; each read feeds a two-stage compare pipeline that records the
// first failing address and element.
//
//  state | meaning
//  IDLE  | waiting for a 0->1 edge on mode
//  RUN   | issuing March ops, one per en tick
//  CHECK | last read issued; waiting for its compare to land
//  DONE  | result valid; back to IDLE on mode=0, restart on a new edge
module bist_march_engine #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);
    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              phase_q, phase_d;
    logic              mode_q;
    logic              chk_wait_q;

    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              ram_we_q, ram_re_q;
    logic              exp1_bit_q, exp2_bit_q;
    logic [ADDR_W-1:0] exp1_addr_q, exp2_addr_q;
    logic [2:0]        exp1_elem_q, exp2_elem_q;
    logic              cmp_v_q;
    logic              done_q, fail_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic [2:0]        fail_elem_q;

    logic start, op_read, two_op, down, rd_bit, wr_bit, elem_last, step;

    // Decode the current March element into op type, direction and data.
    always_comb begin
        start     = mode & ~mode_q & ((state_q == IDLE) | (state_q == DONE));
        op_read   = (elem_q != 3'd0) & ~phase_q;
        two_op    = (elem_q >= 3'd1) & (elem_q <= 3'd4);
        down      = (elem_q == 3'd3) | (elem_q == 3'd4);
        rd_bit    = (elem_q == 3'd2) | (elem_q == 3'd4);
        wr_bit    = (elem_q == 3'd1) | (elem_q == 3'd3);
        elem_last = down ? (addr_q == '0) : (addr_q == ADDR_MAX);
        step      = ~two_op | phase_q;
    end

    // Next-state logic: sequence phase, address and element.
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    elem_d  = '0;
                    addr_d  = '0;
                    phase_d = 1'b0;
                end else if ((state_q == DONE) && !mode) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (en) begin
                    if (!step) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (!elem_last) begin
                            addr_d = down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
                        end else if (elem_q == 3'd5) begin
                            state_d = CHECK;
                        end else begin
                            elem_d = elem_q + 3'd1;
                            // E3 and E4 descend; everything else ascends.
                            addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
                        end
                    end
                end
            end
            CHECK: begin
                if (chk_wait_q) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers and mode edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            elem_q     <= '0;
            addr_q     <= '0;
            phase_q    <= 1'b0;
            mode_q     <= 1'b0;
            chk_wait_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            elem_q     <= elem_d;
            addr_q     <= addr_d;
            phase_q    <= phase_d;
            mode_q     <= mode;
            chk_wait_q <= (state_q == CHECK) & ~chk_wait_q;
        end
    end

    // RAM port, compare pipeline and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            exp1_bit_q  <= 1'b0;
            exp1_addr_q <= '0;
            exp1_elem_q <= '0;
            exp2_bit_q  <= 1'b0;
            exp2_addr_q <= '0;
            exp2_elem_q <= '0;
            cmp_v_q     <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
        end else begin
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            // Read data arrives the clk after the strobe, so expectations
            // move one stage along to line up with it.
            cmp_v_q     <= ram_re_q;
            exp2_bit_q  <= exp1_bit_q;
            exp2_addr_q <= exp1_addr_q;
            exp2_elem_q <= exp1_elem_q;
            if ((state_q == RUN) && en) begin
                ram_addr_q  <= addr_q;
                ram_wdata_q <= op_read ? '0 : {DATA_W{wr_bit}};
                ram_we_q    <= ~op_read;
                ram_re_q    <= op_read;
                if (op_read) begin
                    exp1_bit_q  <= rd_bit;
                    exp1_addr_q <= addr_q;
                    exp1_elem_q <= elem_q;
                end
            end
            if (start) begin
                done_q      <= 1'b0;
                fail_q      <= 1'b0;
                fail_addr_q <= '0;
                fail_elem_q <= '0;
                cmp_v_q     <= 1'b0;
            end else begin
                if ((state_q == CHECK) && chk_wait_q) done_q <= 1'b1;
                if (cmp_v_q && (ram_rdata != {DATA_W{exp2_bit_q}}) && !fail_q) begin
                    fail_q      <= 1'b1;
                    fail_addr_q <= exp2_addr_q;
                    fail_elem_q <= exp2_elem_q;
                end
            end
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign ram_re    = ram_re_q;
    assign busy      = (state_q == RUN) | (state_q == CHECK);
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
endmodule

// File: tb/tb_bist_march_engine.sv
// Bench for bist_march_engine: a synchronous RAM model with optional faults,
// a March C- op-table model, and a monitor checking every issued op.
module tb_bist_march_engine;
    localparam int NOPS = 160;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_we, ram_re;
    logic [7:0] ram_rdata = 8'h00;
    logic       busy, done, fail;
    logic [3:0] fail_addr;
    logic [2:0] fail_elem;

    bist_march_engine #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
        .ram_rdata(ram_rdata), .busy(busy), .done(done), .fail(fail),
        .fail_addr(fail_addr), .fail_elem(fail_elem)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected op stream: {we, re, addr, wdata} and element per op
    logic [13:0] exp_op [NOPS];
    logic [2:0]  exp_el [NOPS];

    function automatic void build_table();
        int rbit [6] = '{0, 0, 1, 0, 1, 0};
        int wbit [6] = '{0, 1, 0, 1, 0, 0};
        int k = 0;
        logic [3:0] a;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < 16; i++) begin
                a = 4'((e == 3 || e == 4) ? 15 - i : i);
                if (e != 0) begin
                    exp_op[k] = {1'b0, 1'b1, a, 8'h00};
                    exp_el[k] = 3'(e);
                    k++;
                end
                if (e != 5) begin
                    exp_op[k] = {1'b1, 1'b0, a, (wbit[e] != 0) ? 8'hFF : 8'h00};
                    exp_el[k] = 3'(e);
                    k++;
                end
            end
            if (rbit[e] > 1) k = 0;
        end
    endfunction

    // Cycle counter and en as seen by the DUT at each rising edge
    int   cyc = 0;
    logic en_at_edge = 1'b0;
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        en_at_edge <= en;
    end

    // RAM model: 1-clk read latency, optional stuck-at or coupling fault
    int         fault_mode = 0;
    logic [2:0] mon_elem = 3'd0;
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            if (fault_mode == 2 && mon_elem == 3'd3 && ram_addr == 4'd4 && ram_wdata == 8'hFF)
                mem[3] <= 8'hFF;
        end
        if (ram_re)
            ram_rdata <= mem[ram_addr] | ((fault_mode == 1 && ram_addr == 4'd5) ? 8'h08 : 8'h00);
    end

    // Op monitor: every strobe must match the next entry of the op table
    bit mon_on = 1'b0;
    int op_idx = 0;
    int p0 = 0;
    int cur_div = 1;
    int last_strobe = 0;
    always @(negedge clk) begin
        if (mon_on && rst_n && (ram_we || ram_re)) begin
            chk("one_strobe", 32'(ram_we & ram_re), 32'd0);
            chk("strobe_on_tick", 32'(en_at_edge), 32'd1);
            if (op_idx >= NOPS) begin
                chk("extra_op", 32'(op_idx), 32'(NOPS - 1));
            end else begin
                chk("op", 32'({ram_we, ram_re, ram_addr, ram_wdata}), 32'(exp_op[op_idx]));
                if (cur_div == 1) chk("op_cyc", 32'(cyc), 32'(p0 + op_idx + 1));
                mon_elem = exp_el[op_idx];
                op_idx++;
            end
            last_strobe = cyc;
        end
    end

    task automatic start_run(input int div);
        @(negedge clk);
        mode = 1'b0;
        en   = 1'b1;
        @(negedge clk);
        op_idx      = 0;
        cur_div     = div;
        last_strobe = 0;
        mon_on      = 1'b1;
        p0          = cyc + 1;
        mode        = 1'b1;
    endtask

    task automatic run(input int fault, input int div, input logic [31:0] xf,
                       input logic [31:0] xa, input logic [31:0] xe, input bit tog);
        bit got = 1'b0;
        fault_mode = fault;
        start_run(div);
        for (int c = 0; c < NOPS * div * 2 + 50 && !got; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("start_done_clr", 32'(done), 32'd0);
                chk("start_fail_clr", 32'(fail), 32'd0);
            end
            chk("busy", 32'(busy), 32'(!done));
            if (done) got = 1'b1;
            if (tog) mode = !(op_idx >= 30 && op_idx < 60);
            en = (((cyc + 1 - p0) % div) == 0);
        end
        if (!got) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("done_lat", 32'(cyc), 32'(last_strobe + 2));
            if (div == 1) chk("done_cyc", 32'(cyc), 32'(p0 + 162));
            chk("op_count", 32'(op_idx), 32'(NOPS));
            chk("fail", 32'(fail), xf);
            chk("fail_addr", 32'(fail_addr), xa);
            chk("fail_elem", 32'(fail_elem), xe);
        end
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("held_done", 32'(done), 32'd1);
            chk("held_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        build_table();
        chk("tbl_first", 32'(exp_op[0]),   32'({1'b1, 1'b0, 4'd0, 8'h00}));
        chk("tbl_e1_w1", 32'(exp_op[17]),  32'({1'b1, 1'b0, 4'd0, 8'hFF}));
        chk("tbl_e3_r0", 32'(exp_op[80]),  32'({1'b0, 1'b1, 4'd15, 8'h00}));
        chk("tbl_e4_el", 32'(exp_el[112]), 32'd4);
        chk("tbl_e4_w0", 32'(exp_op[143]), 32'({1'b1, 1'b0, 4'd0, 8'h00}));
        chk("tbl_last",  32'(exp_op[159]), 32'({1'b0, 1'b1, 4'd15, 8'h00}));

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        chk("reset_outputs", 32'({ram_addr, ram_wdata, ram_we, ram_re, busy, done, fail,
                                  fail_addr, fail_elem}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // T1 clean run; mode drops and re-rises mid-run, both ignored
        run(0, 1, 32'd0, 32'd0, 32'd0, 1'b1);
        hold(20);

        // T2 stuck-at-1 on bit3 at addr5, then mode held high: no restart
        run(1, 1, 32'd1, 32'd5, 32'd1, 1'b0);
        hold(20);

        // T6 fresh edge after a failing run clears results and reruns clean
        run(0, 1, 32'd0, 32'd0, 32'd0, 1'b0);

        // T3 coupling: w1 to addr4 in E3 forces addr3 to 1 before E3 reads it
        run(2, 1, 32'd1, 32'd3, 32'd3, 1'b0);

        // T4 en on every 4th clk
        run(0, 4, 32'd0, 32'd0, 32'd0, 1'b0);

        // T5 reset mid-run at op 50, then a full clean run
        fault_mode = 0;
        start_run(1);
        for (int c = 0; c < 200 && op_idx < 50; c++) @(negedge clk);
        chk("t5_op50_reached", 32'(op_idx >= 50), 32'd1);
        chk("t5_busy_before", 32'(busy), 32'd1);
        rst_n  = 1'b0;
        mode   = 1'b0;
        mon_on = 1'b0;
        #1;
        chk("t5_reset_outputs", 32'({ram_addr, ram_wdata, ram_we, ram_re, busy, done, fail,
                                     fail_addr, fail_elem}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(0, 1, 32'd0, 32'd0, 32'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
